snoop_resp_collector: RTL

SNOOP_RESP_COLLECTOR -- requirements
Module: snoop_resp_collector

---
 rtl/snoop_resp_collector_pkg.sv | 28 ++
 rtl/snoop_resp_collector_skid.sv | 45 ++++
 rtl/snoop_resp_collector.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/snoop_resp_collector_pkg.sv
// Shared cache-bus types and the snoop response collector state encoding.
package snoop_resp_collector_pkg;

  typedef enum logic [1:0] {
    bus_rd    = 2'd0,
    bus_rdx   = 2'd1,
    bus_upgr  = 2'd2,
    bus_flush = 2'd3
  } bus_req_type_t;

  typedef struct packed {
    bus_req_type_t req_type;
    logic [3:0]    src_id;
    logic [31:0]   addr;
  } cache_bus_pkt_t;

  localparam int cache_bus_pkt_width = $bits(cache_bus_pkt_t);

  typedef enum logic [2:0] {
    s_idle  = 3'd0,
    s_begin = 3'd1,
    s_check = 3'd2,
    s_wait  = 3'd3,
    s_fwd   = 3'd4,
    s_done  = 3'd5
  } collector_state_e;

endpackage

// File: rtl/snoop_resp_collector_skid.sv
// One-entry skid register for forwarded bus beats. The output shows the
// held beat when one is stored, otherwise the live beat passes straight through.
// Handshake: a beat moves when out_valid_o & out_ready_i; the source has no
// back-pressure, so it must not present a new beat while a held beat is stalled.
module bus_beat_skid #(
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               clr_i,
  input  logic               in_valid_i,
  input  logic [width_p-1:0] in_data_i,
  input  logic               out_ready_i,
  output logic               out_valid_o,
  output logic [width_p-1:0] out_data_o
);

  logic               full_q;
  logic [width_p-1:0] data_q;

  // Capture a live beat that cannot leave this cycle; refill behind an accepted held beat.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (full_q) begin
      if (out_ready_i) begin
        if (in_valid_i) data_q <= in_data_i;
        else            full_q <= 1'b0;
      end
    end else if (in_valid_i && !out_ready_i) begin
      full_q <= 1'b1;
      data_q <= in_data_i;
    end
  end

  // Held beat has priority so ordering is preserved.
  always_comb begin
    out_valid_o = full_q | in_valid_i;
    out_data_o  = full_q ? data_q : in_data_i;
  end

endmodule

// File: rtl/snoop_resp_collector.sv
// Broadcasts a granted bus request to the snoopers, collects hit/wait
// responses, forwards a dirty block from its owner or asks memory for it.
// Handshakes: req is accepted when req_valid_i & req_ready_o; a response beat
// is accepted when resp_valid_o & resp_ready_i. Snoop data has no back-pressure.
module snoop_resp_collector
  import snoop_resp_collector_pkg::*;
#(
  parameter int num_caches_p     = 4,
  parameter int dma_data_width_p = 4,
  parameter int block_width_p    = 16,
  localparam int id_w            = (num_caches_p > 1) ? $clog2(num_caches_p) : 1,
  localparam int beat_w          = dma_data_width_p * 32,
  localparam int beats_per_block = block_width_p / dma_data_width_p,
  localparam int cnt_w           = (beats_per_block > 1) ? $clog2(beats_per_block) : 1
) (
  input  logic                           clk_i,
  input  logic                           nreset_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  cache_bus_pkt_t                 req_pkt_i,
  input  logic [id_w-1:0]                req_id_i,
  output logic [num_caches_p-1:0]        snp_valid_o,
  output logic                           snp_tx_begin_o,
  output logic [num_caches_p-1:0]        snp_last_rx_o,
  output cache_bus_pkt_t                 snp_pkt_o,
  input  logic [num_caches_p-1:0]        snp_wait_i,
  input  logic [num_caches_p-1:0]        snp_hit_i,
  input  logic [num_caches_p-1:0]        snp_valid_i,
  input  logic [num_caches_p*beat_w-1:0] snp_data_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [beat_w-1:0]              resp_data_o,
  output logic                           resp_last_o,
  output logic                           resp_shared_o,
  output logic                           resp_fwd_o,
  output logic [31:0]                    resp_addr_o,
  output logic                           mem_fetch_o,
  output collector_state_e               state_o
);

  localparam logic [31:0] addr_step = 32'(dma_data_width_p * 4);

  collector_state_e        state_q, state_d;
  cache_bus_pkt_t          pkt_q;
  logic [id_w-1:0]         req_id_q, owner_q, first_k, owner_sel;
  logic [cnt_w-1:0]        cnt_q;
  logic                    shared_q, fwd_q;
  logic [num_caches_p-1:0] nonreq_mask, wait_nr, hit_nr, valid_nr;
  logic [beat_w-1:0]       sel_data, skid_data;
  logic                    skid_in_valid, skid_out_valid, skid_out_ready;
  logic                    accept, is_last;

  // Requester's own snoop responses are masked out everywhere.
  always_comb begin
    nonreq_mask           = '1;
    nonreq_mask[req_id_q] = 1'b0;
    wait_nr               = snp_wait_i & nonreq_mask;
    hit_nr                = snp_hit_i & nonreq_mask;
    valid_nr              = snp_valid_i & nonreq_mask;
  end

  // Lowest-index data responder wins; the data lane follows the latched owner once forwarding.
  always_comb begin
    first_k = '0;
    for (int i = num_caches_p - 1; i >= 0; i--) begin
      if (valid_nr[i]) first_k = id_w'(i);
    end
    owner_sel = (state_q == s_fwd) ? owner_q : first_k;
    sel_data  = '0;
    for (int i = 0; i < num_caches_p; i++) begin
      if (owner_sel == id_w'(i)) sel_data = snp_data_i[i*beat_w +: beat_w];
    end
  end

  // The first beat seen while waiting lands in the skid and is presented from s_fwd.
  always_comb begin
    skid_in_valid  = ((state_q == s_wait) && (|valid_nr)) ||
                     ((state_q == s_fwd) && valid_nr[owner_q]);
    skid_out_ready = (state_q == s_fwd) && resp_ready_i;
  end

  bus_beat_skid #(.width_p(beat_w)) u_skid (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .clr_i       (state_q == s_idle),
    .in_valid_i  (skid_in_valid),
    .in_data_i   (sel_data),
    .out_ready_i (skid_out_ready),
    .out_valid_o (skid_out_valid),
    .out_data_o  (skid_data)
  );

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d        = state_q;
    resp_valid_o   = (state_q == s_fwd) && skid_out_valid;
    accept         = resp_valid_o && resp_ready_i;
    is_last        = (cnt_q == cnt_w'(beats_per_block - 1));
    req_ready_o    = (state_q == s_idle);
    snp_tx_begin_o = (state_q == s_begin);
    snp_valid_o    = (state_q == s_idle) ? '0 : nonreq_mask;
    mem_fetch_o    = (state_q == s_done) && !fwd_q;
    resp_data_o    = (state_q == s_fwd) ? skid_data : '0;
    resp_last_o    = resp_valid_o && is_last;
    snp_last_rx_o  = '0;
    if ((state_q == s_fwd) && is_last) snp_last_rx_o[owner_q] = 1'b1;
    case (state_q)
      s_idle:  if (req_valid_i) state_d = s_begin;
      s_begin: state_d = s_check;
      s_check: state_d = (|wait_nr) ? s_wait : s_done;
      s_wait: begin
        if (|valid_nr)      state_d = s_fwd;
        else if (!(|wait_nr)) state_d = s_done;
      end
      s_fwd:   if (accept && is_last) state_d = s_done;
      s_done:  state_d = s_idle;
      default: state_d = s_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state_q <= s_idle;
    else           state_q <= state_d;
  end

  // Request latch, snoop summary, owner and beat/address tracking.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      pkt_q    <= '0;
      req_id_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      shared_q <= 1'b0;
      fwd_q    <= 1'b0;
    end else begin
      if ((state_q == s_idle) && req_valid_i) begin
        pkt_q    <= req_pkt_i;
        req_id_q <= req_id_i;
        owner_q  <= '0;
        cnt_q    <= '0;
        shared_q <= 1'b0;
        fwd_q    <= 1'b0;
      end
      if (state_q == s_check) shared_q <= |hit_nr;
      if ((state_q == s_wait) && (|valid_nr)) begin
        owner_q <= first_k;
        fwd_q   <= 1'b1;
      end
      if (accept) begin
        cnt_q      <= cnt_q + cnt_w'(1);
        pkt_q.addr <= pkt_q.addr + addr_step;
      end
    end
  end

  // Registered status outputs.
  always_comb begin
    resp_shared_o = shared_q;
    resp_fwd_o    = fwd_q;
    resp_addr_o   = pkt_q.addr;
    snp_pkt_o     = pkt_q;
    state_o       = state_q;
  end

`ifndef SYNTHESIS
  // Two caches returning data together means two owners of one block.
  always_ff @(posedge clk_i) begin
    if (nreset_i && (state_q == s_wait)) begin
      assert ($countones(valid_nr) <= 1)
        else $warning("snoop_resp_collector: %0d caches returned data together",
                      $countones(valid_nr));
    end
  end
`endif

endmodule
